// File: rtl/upload_stream_arbiter.sv
// Round-robin merger of NUM_CH byte streams into one framed upload stream.
// Each channel writes into its own show-ahead FIFO. The arbiter drains one
// channel at a time as a packet: SYNC_BYTE, channel id, length, payload.
// Downstream almost-full stalls emission without losing or repeating bytes.
module upload_stream_arbiter #(
  parameter int                NUM_CH     = 4,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 64,
  parameter int                MAX_BURST  = 32,
  parameter logic [DATA_W-1:0] SYNC_BYTE  = 8'hAA
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]        ch_valid_in,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     out_afull,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        ovf_flags,
  input  logic [NUM_CH-1:0]        ovf_clear,
  output logic                     busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_SYNC,
    ST_HDR_ID,
    ST_HDR_LEN,
    ST_PAYLOAD
  } state_t;

  logic [DATA_W-1:0] r_mem   [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     r_wptr  [NUM_CH];
  logic [AW-1:0]     r_rptr  [NUM_CH];
  logic [CW-1:0]     r_count [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;

  state_t            r_state, w_state_next;
  logic [GW-1:0]     r_gid, w_gid_next;
  logic [GW-1:0]     r_last_grant, w_last_next;
  logic [DATA_W-1:0] r_len, w_len_next;
  logic [DATA_W-1:0] r_pcnt, w_pcnt_next;
  logic [DATA_W-1:0] r_out_data, w_out_data_next;
  logic              r_out_valid, w_out_valid_next;

  logic [NUM_CH-1:0] w_push, w_pop, w_drop, w_nonempty;
  logic              w_pop_en;
  logic              w_found;
  logic [GW-1:0]     w_pick, w_cand;
  int                w_idx;
  logic [DATA_W-1:0] w_head, w_pick_len;

  // Per-channel push/pop/drop decisions; a pop frees room for a same-cycle push
  always_comb begin
    w_pop_en   = (r_state == ST_PAYLOAD) && !out_afull;
    w_nonempty = '0;
    w_pop      = '0;
    w_push     = '0;
    w_drop     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_nonempty[k] = (r_count[k] != '0);
      w_pop[k]      = w_pop_en && (r_gid == GW'(k));
      w_push[k]     = ch_valid_in[k] && ch_enable[k] &&
                      ((r_count[k] != CW'(FIFO_DEPTH)) || w_pop[k]);
      w_drop[k]     = ch_valid_in[k] && ch_enable[k] &&
                      (r_count[k] == CW'(FIFO_DEPTH)) && !w_pop[k];
    end
  end

  // FIFO storage writes; contents need no reset because counts gate every read
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wptr[k]] <= ch_data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and occupancy counts; reset empties every channel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_push[k]) begin
          r_wptr[k] <= r_wptr[k] + AW'(1);
        end
        if (w_pop[k]) begin
          r_rptr[k] <= r_rptr[k] + AW'(1);
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CW'(1);
          2'b01:   r_count[k] <= r_count[k] - CW'(1);
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // Sticky overflow flags; a new drop wins over a coincident clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~ovf_clear) | w_drop;
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_cand     = '0;
    w_idx      = 0;
    w_pick_len = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = int'(r_last_grant) + i;
      if (w_idx >= NUM_CH) begin
        w_idx = w_idx - NUM_CH;
      end
      w_cand = GW'(w_idx);
      if (!w_found && w_nonempty[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
    if (r_count[w_pick] > CW'(MAX_BURST)) begin
      w_pick_len = DATA_W'(MAX_BURST);
    end else begin
      w_pick_len = DATA_W'(r_count[w_pick]);
    end
  end

  // Show-ahead head word of the granted channel
  always_comb begin
    w_head = r_mem[r_gid][r_rptr[r_gid]];
  end

  // Next-state and next-output logic; every emitting state stalls on afull
  always_comb begin
    w_state_next     = r_state;
    w_gid_next       = r_gid;
    w_len_next       = r_len;
    w_pcnt_next      = r_pcnt;
    w_last_next      = r_last_grant;
    w_out_data_next  = r_out_data;
    w_out_valid_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!out_afull && w_found) begin
          w_gid_next   = w_pick;
          w_len_next   = w_pick_len;
          w_pcnt_next  = '0;
          w_state_next = ST_HDR_SYNC;
        end
      end
      ST_HDR_SYNC: begin
        if (!out_afull) begin
          w_out_data_next  = SYNC_BYTE;
          w_out_valid_next = 1'b1;
          w_state_next     = ST_HDR_ID;
        end
      end
      ST_HDR_ID: begin
        if (!out_afull) begin
          w_out_data_next  = DATA_W'(r_gid);
          w_out_valid_next = 1'b1;
          w_state_next     = ST_HDR_LEN;
        end
      end
      ST_HDR_LEN: begin
        if (!out_afull) begin
          w_out_data_next  = r_len;
          w_out_valid_next = 1'b1;
          w_state_next     = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!out_afull) begin
          w_out_data_next  = w_head;
          w_out_valid_next = 1'b1;
          if (r_pcnt == r_len - DATA_W'(1)) begin
            w_state_next = ST_IDLE;
            w_last_next  = r_gid;
          end else begin
            w_pcnt_next = r_pcnt + DATA_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, packet context and registered output byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gid        <= '0;
      r_len        <= '0;
      r_pcnt       <= '0;
      r_last_grant <= GW'(NUM_CH - 1);
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_gid        <= w_gid_next;
      r_len        <= w_len_next;
      r_pcnt       <= w_pcnt_next;
      r_last_grant <= w_last_next;
      r_out_data   <= w_out_data_next;
      r_out_valid  <= w_out_valid_next;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign ovf_flags = r_ovf;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_upload_stream_arbiter.sv
// Self-checking bench for upload_stream_arbiter: table-driven packet vectors
// plus hand sequences for ordering, stalls, overflow, disable and reset.
// Expected framed bytes go into a queue as stimulus is written and are
// compared as the DUT emits them.
module tb_upload_stream_arbiter;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 64;
  localparam int MAX_BURST  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] ch_data_in;
  logic [NUM_CH-1:0]        ch_valid_in;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     out_afull;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic [NUM_CH-1:0]        ovf_flags;
  logic [NUM_CH-1:0]        ovf_clear;
  logic                     busy;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  typedef struct {
    int ch;
    int n;
    int base;
    int step;
    int expPkts;
  } vec_t;

  exp_t expQ[$];
  exp_t monItem;
  vec_t vecs[5];
  int   total = 0;
  int   bad = 0;
  int   rxCount = 0;
  int   pktCount = 0;
  bit   expectGap = 1'b0;
  int   pk0;
  int   r0;
  int   cyc;

  upload_stream_arbiter #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_BURST (MAX_BURST),
    .SYNC_BYTE (8'hAA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_data_in (ch_data_in),
    .ch_valid_in(ch_valid_in),
    .ch_enable  (ch_enable),
    .out_afull  (out_afull),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .ovf_flags  (ovf_flags),
    .ovf_clear  (ovf_clear),
    .busy       (busy)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] d, input bit last);
    exp_t e;
    e.data = d;
    e.last = last;
    expQ.push_back(e);
  endtask

  // Frame n bytes of one channel into packets of at most MAX_BURST bytes
  task automatic pushExpected(input int ch, input int n, input int base, input int step);
    int len;
    for (int i = 0; i < n; i++) begin
      if (i % MAX_BURST == 0) begin
        len = (n - i < MAX_BURST) ? (n - i) : MAX_BURST;
        pushByte(8'hAA, 1'b0);
        pushByte(8'(ch), 1'b0);
        pushByte(8'(len), 1'b0);
      end
      pushByte(8'(base + i * step),
               (i % MAX_BURST == MAX_BURST - 1) || (i == n - 1));
    end
  endtask

  // Write n bytes on one channel; the first nAccept become expected output
  task automatic applyStimulus(input int ch, input int n, input int base, input int step,
                               input int nAccept, input bit doPush);
    if (doPush) pushExpected(ch, nAccept, base, step);
    for (int i = 0; i < n; i++) begin
      ch_valid_in[ch] = 1'b1;
      ch_data_in[ch*DATA_W +: DATA_W] = 8'(base + i * step);
      tick();
    end
    ch_valid_in[ch] = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int c;
    c = 0;
    while ((expQ.size() != 0 || busy || out_valid) && c < 2000) begin
      tick();
      c++;
    end
    repeat (3) tick();
    checkOutput({name, " queue drained"}, expQ.size(), 0);
    checkOutput({name, " busy after drain"}, {31'b0, busy}, 0);
  endtask

  // Output monitor: pops the scoreboard on each valid byte, checks packet gaps
  always @(negedge clk) begin
    if (expectGap) begin
      checkOutput("idle gap after packet", {31'b0, out_valid}, 0);
      expectGap = 1'b0;
    end
    if (out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious out_valid", {31'b0, out_valid}, 0);
      end else begin
        monItem = expQ.pop_front();
        checkOutput("out_data", {24'b0, out_data}, {24'b0, monItem.data});
        rxCount++;
        if (monItem.last) begin
          pktCount++;
          expectGap = 1'b1;
        end
      end
    end
  end

  // Main test sequence
  initial begin
    vecs[0] = '{ch: 0, n: 3,  base: 'h11, step: 'h11, expPkts: 1};
    vecs[1] = '{ch: 0, n: 40, base: 0,    step: 1,    expPkts: 2};
    vecs[2] = '{ch: 3, n: 32, base: 'h80, step: 1,    expPkts: 1};
    vecs[3] = '{ch: 1, n: 33, base: 'h20, step: 3,    expPkts: 2};
    vecs[4] = '{ch: 2, n: 1,  base: 'hFE, step: 0,    expPkts: 1};

    rst_n       = 1'b0;
    ch_data_in  = '0;
    ch_valid_in = '0;
    ch_enable   = '1;
    out_afull   = 1'b0;
    ovf_clear   = '0;
    repeat (2) tick();
    checkOutput("reset out_valid", {31'b0, out_valid}, 0);
    checkOutput("reset out_data", {24'b0, out_data}, 0);
    checkOutput("reset busy", {31'b0, busy}, 0);
    checkOutput("reset ovf_flags", {28'b0, ovf_flags}, 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      pk0 = pktCount;
      out_afull = 1'b1;
      applyStimulus(vecs[v].ch, vecs[v].n, vecs[v].base, vecs[v].step, vecs[v].n, 1'b1);
      tick();
      checkOutput("idle while afull", {31'b0, busy}, 0);
      out_afull = 1'b0;
      waitDrain("vector");
      checkOutput("vector packet count", pktCount - pk0, vecs[v].expPkts);
    end

    $display("[TB] round-robin order");
    out_afull = 1'b1;
    applyStimulus(2, 2, 'hC1, 1, 2, 1'b0);
    applyStimulus(1, 2, 'hB1, 1, 2, 1'b1);
    pushExpected(2, 2, 'hC1, 1);
    out_afull = 1'b0;
    waitDrain("round robin");

    $display("[TB] afull stall mid-payload");
    r0 = rxCount;
    out_afull = 1'b1;
    applyStimulus(0, 12, 'h40, 1, 12, 1'b1);
    out_afull = 1'b0;
    cyc = 0;
    while (rxCount < r0 + 5 && cyc < 100) begin
      tick();
      cyc++;
    end
    checkOutput("reached payload", {31'b0, (rxCount >= r0 + 5)}, 1);
    out_afull = 1'b1;
    repeat (5) begin
      tick();
      checkOutput("stall out_valid", {31'b0, out_valid}, 0);
      checkOutput("stall busy", {31'b0, busy}, 1);
    end
    out_afull = 1'b0;
    waitDrain("stall");

    $display("[TB] disabled channel");
    ch_enable[2] = 1'b0;
    out_afull = 1'b1;
    applyStimulus(2, 70, 0, 1, 0, 1'b0);
    tick();
    checkOutput("disabled no ovf", {28'b0, ovf_flags}, 0);
    out_afull = 1'b0;
    repeat (6) tick();
    checkOutput("disabled stays idle", {31'b0, busy}, 0);
    ch_enable[2] = 1'b1;

    $display("[TB] overflow");
    out_afull = 1'b1;
    applyStimulus(3, 70, 0, 1, 64, 1'b1);
    tick();
    checkOutput("ovf set", {28'b0, ovf_flags}, 32'h8);
    ovf_clear[3] = 1'b1;
    ch_valid_in[3] = 1'b1;
    ch_data_in[3*DATA_W +: DATA_W] = 8'hEE;
    tick();
    ovf_clear[3] = 1'b0;
    ch_valid_in[3] = 1'b0;
    tick();
    checkOutput("ovf set wins over clear", {28'b0, ovf_flags}, 32'h8);
    ovf_clear[3] = 1'b1;
    tick();
    ovf_clear[3] = 1'b0;
    tick();
    checkOutput("ovf cleared", {28'b0, ovf_flags}, 0);
    out_afull = 1'b0;
    waitDrain("overflow");

    $display("[TB] reset mid-payload");
    out_afull = 1'b1;
    applyStimulus(2, 20, 'h70, 1, 20, 1'b1);
    applyStimulus(3, 65, 0, 1, 0, 1'b0);
    checkOutput("ovf before reset", {28'b0, ovf_flags}, 32'h8);
    out_afull = 1'b0;
    r0 = rxCount;
    cyc = 0;
    while (rxCount < r0 + 6 && cyc < 100) begin
      tick();
      cyc++;
    end
    checkOutput("reached payload before reset", {31'b0, (rxCount >= r0 + 6)}, 1);
    rst_n = 1'b0;
    expQ.delete();
    expectGap = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("post-reset out_valid", {31'b0, out_valid}, 0);
    checkOutput("post-reset busy", {31'b0, busy}, 0);
    checkOutput("post-reset ovf_flags", {28'b0, ovf_flags}, 0);

    pushExpected(0, 1, 'h5A, 0);
    pushExpected(1, 1, 'h6B, 0);
    ch_data_in[0*DATA_W +: DATA_W] = 8'h5A;
    ch_data_in[1*DATA_W +: DATA_W] = 8'h6B;
    ch_valid_in = 4'b0011;
    tick();
    ch_valid_in = '0;
    tick();
    checkOutput("latency no early output", {31'b0, out_valid}, 0);
    tick();
    checkOutput("latency sync valid", {31'b0, out_valid}, 1);
    checkOutput("latency sync byte", {24'b0, out_data}, 32'hAA);
    waitDrain("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upload_stream_arbiter.md
Name: upload_stream_arbiter

Overview:
Generalised N-channel upload merger for the USB CDC upload path. It replaces the fixed pair of independent upload streams (command upload and digital capture upload) with a single framed byte stream. Each source channel pushes bytes with a valid-only strobe into its own FIFO. A round-robin arbiter drains the FIFOs as framed packets toward the CDC upload port and honours the downstream almost-full backpressure.

Parameters:
NUM_CH, 4, number of source channels (1..16)
DATA_W, 8, byte width of channel and output data
FIFO_DEPTH, 64, per-channel FIFO depth in words; must be a power of 2
MAX_BURST, 32, maximum payload bytes per packet; 1..(2^DATA_W - 1) and ≤ FIFO_DEPTH
SYNC_BYTE, 8'hAA, packet header marker

Ports:
clk  in  1  system clock (PHY_CLK domain)
rst_n  in  1  reset, synchronous, active-low
ch_data_in  in  NUM_CH*DATA_W  channel k data in bits [k*DATA_W +: DATA_W]
ch_valid_in  in  NUM_CH  per-channel write strobe, one byte per cycle, no ready
ch_enable  in  NUM_CH  1 = channel accepts writes; 0 = writes ignored, FIFO still drains
out_afull  in  1  downstream almost full; 1 = emit nothing this cycle
out_data  out  DATA_W  framed output byte
out_valid  out  1  out_data qualifier
ovf_flags  out  NUM_CH  sticky per-channel overflow
ovf_clear  in  NUM_CH  per-channel overflow clear pulse
busy  out  1  1 while the FSM is not in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_data=0, out_valid=0, ovf_flags=0, busy=0.
  - All FIFOs empty; FSM to IDLE.
  - last_grant=NUM_CH-1, so channel 0 has first priority.
  - A packet in flight is truncated; no further bytes of it are ever emitted.
- FIFO write:
  - Accepted iff ch_valid_in[k] & ch_enable[k] & (count_k < FIFO_DEPTH, or a pop from k occurs in the same cycle).
  - A rejected write (valid & enable & full & no pop) drops the byte and sets ovf_flags[k].
  - ch_valid_in while disabled is silently ignored and does not set the flag.
  - Simultaneous push and pop on the same FIFO leaves count unchanged.
  - Count is registered and visible the cycle after the write edge.
- Overflow flags: ovf_clear[k] clears ovf_flags[k]; if set and clear coincide, set wins.
- FSM states: IDLE, HDR_SYNC, HDR_ID, HDR_LEN, PAYLOAD.
- IDLE:
  - Condition: out_afull=0 and at least one count_k>0.
  - Grant the first non-empty channel searching last_grant+1, +2, … modulo NUM_CH.
  - Latch gid and len=min(count_gid, MAX_BURST); go to HDR_SYNC.
  - out_valid=0 in IDLE.
- Emission:
  - HDR_SYNC emits SYNC_BYTE, HDR_ID emits gid zero-extended to DATA_W, HDR_LEN emits len.
  - PAYLOAD emits len bytes popped in order from FIFO gid.
  - Each state emits one registered byte per cycle with out_valid=1, but only in cycles where out_afull=0.
  - When out_afull=1, out_valid=0 and the state and payload counter hold; no byte is lost or duplicated.
- FIFO read: show-ahead (the head word is available combinationally to the output register); one pop per emitted payload byte.
- Packet end: after the last payload byte, go to IDLE and set last_grant=gid.
  - There is at least one idle cycle between packets.
  - Bytes arriving in FIFO gid during the packet remain queued for a later packet.
- Latency: a byte written to an empty FIFO with out_afull=0 and the FSM in IDLE produces the SYNC byte 3 cycles after its write cycle (count register, IDLE decision, output register).
- Throughput: 3 header bytes + len payload bytes per packet; MAX_BURST bounds starvation of the other channels.

Test Plan:
1. Hold out_afull=1; write 0x11,0x22,0x33 on ch0; release out_afull -> out stream AA,00,03,11,22,33 on 6 consecutive valid cycles; busy=0 afterwards.
2. Hold out_afull=1; write 2 bytes on ch2 (0xC1,0xC2), then 2 bytes on ch1 (0xB1,0xB2); release -> AA,01,02,B1,B2, then after ≥1 idle cycle AA,02,02,C1,C2.
3. Hold out_afull=1; write 40 bytes 0..39 on ch0; release -> packet len 0x20 carrying 0..31, then packet len 0x08 carrying 32..39.
4. During PAYLOAD, assert out_afull for 5 cycles -> out_valid=0 for those cycles; the resumed stream continues with the next sequential byte, with no gap in data values.
5. Hold out_afull=1; write 70 bytes on ch3 -> ovf_flags[3]=1 and bytes 0..63 are delivered. Pulse ovf_clear[3] in the same cycle as a further overflowing write -> flag stays 1. Pulse ovf_clear[3] alone -> flag 0.
6. Assert rst_n=0 for 1 cycle mid-PAYLOAD -> next cycle out_valid=0, busy=0, ovf_flags=0. The next packet starts with the first byte written after reset, on channel 0 priority.
